// File: rtl/target_power_seq_pkg.sv
// Shared constants for the target power sequencer: register address, FSM encodings,
// register bit positions and the STATUS byte packer.
`ifndef TPWR_ADDR
`define TPWR_ADDR 6'd52
`endif

package target_power_seq_pkg;

  localparam logic [5:0] TPWR_ADDR = `TPWR_ADDR;

  localparam logic [2:0] ST_OFF       = 3'd0;
  localparam logic [2:0] ST_SOFTSTART = 3'd1;
  localparam logic [2:0] ST_SETTLE    = 3'd2;
  localparam logic [2:0] ST_ON        = 3'd3;
  localparam logic [2:0] ST_DISCHARGE = 3'd4;
  localparam logic [2:0] ST_FAULT     = 3'd5;

  localparam int CTRL_PWR_REQ   = 0;
  localparam int CTRL_FAULT_CLR = 7;
  localparam int STAT_FAULT     = 3;
  localparam int STAT_PGOOD     = 4;

  // Dwell timer covers SETTLE=255 (65280 cycles) and the discharge window.
  localparam int TIMER_W = 16;

  function automatic logic [7:0] status_byte(input logic [2:0] state,
                                             input logic fault,
                                             input logic pgood);
    logic [7:0] b;
    b = 8'h00;
    b[2:0] = state;
    b[STAT_FAULT] = fault;
    b[STAT_PGOOD] = pgood;
    return b;
  endfunction

endpackage

// File: rtl/target_power_seq_pwm.sv
// tpwr_pwm: soft-start PWM generator. Free-running period counter, duty ramp that
// steps once every (ss_div+1) periods, and a ramp_done pulse after the full-duty step.
module tpwr_pwm
  import target_power_seq_pkg::*;
#(
  parameter int PWM_BITS = 8,
  parameter int SS_STEPS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [7:0] ss_div,
  output logic       pwm_on,
  output logic       ramp_done
);

  localparam int FULL_I = 1 << PWM_BITS;
  localparam int STEP_I = FULL_I / SS_STEPS;
  localparam logic [PWM_BITS:0] FULL = FULL_I[PWM_BITS:0];
  localparam logic [PWM_BITS:0] STEP = STEP_I[PWM_BITS:0];

  logic [PWM_BITS-1:0] cnt_reg;
  logic [PWM_BITS:0]   duty_reg;
  logic [7:0]          div_reg;
  logic                period_end;
  logic                step;

  assign period_end = &cnt_reg;
  assign step       = period_end && (div_reg == ss_div);
  // Full duty also gets its own (ss_div+1) periods before the ramp is declared done.
  assign ramp_done  = run && step && (duty_reg == FULL);
  assign pwm_on     = ({1'b0, cnt_reg} < duty_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg  <= '0;
      duty_reg <= STEP;
      div_reg  <= '0;
    end else if (!run) begin
      cnt_reg  <= '0;
      duty_reg <= STEP;
      div_reg  <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
      if (period_end) begin
        if (step) begin
          div_reg <= '0;
          if (duty_reg != FULL) duty_reg <= duty_reg + STEP;
        end else begin
          div_reg <= div_reg + 8'd1;
        end
      end
    end
  end

endmodule

// File: rtl/target_power_seq.sv
// target_power_seq: sequences target supply (PWM soft-start, settle, discharge) and IO tristate release.
// Define TPWR_OVERCURRENT_EN to add oc_fault_i and the latched FAULT shutdown state.
module target_power_seq
  import target_power_seq_pkg::*;
#(
  parameter int PWM_BITS      = 8,
  parameter int SS_STEPS      = 16,
  parameter int DISCHARGE_CYC = 4096
) (
  input  logic        clk,
  input  logic        reset_i,
`ifdef TPWR_OVERCURRENT_EN
  input  logic        oc_fault_i,
`endif
  input  logic [5:0]  reg_address,
  input  logic [15:0] reg_bytecnt,
  input  logic [7:0]  reg_datai,
  output logic [7:0]  reg_datao,
  input  logic        reg_read,
  input  logic        reg_write,
  input  logic        reg_addrvalid,
  input  logic [5:0]  reg_hypaddress,
  output logic [15:0] reg_hyplen,
  output logic        target_npower,
  output logic        target_highz,
  output logic        power_good
);

  localparam logic [TIMER_W-1:0] DISCH_LAST = TIMER_W'(DISCHARGE_CYC - 1);

  logic [2:0]         state_reg, state_next;
  logic               power_req_reg;
  logic [7:0]         ss_div_reg, settle_reg;
  logic [7:0]         ss_div_snap_reg, settle_snap_reg;
  logic [TIMER_W-1:0] timer_reg, settle_last;
  logic               reg_wr_hit, ctrl_wr, req_now;
  logic               ramping, running, timed;
  logic               pwm_on, ramp_done;
  logic               fault_now, fault_clr_ok;
  logic [7:0]         rd_byte;
  logic               unused_read;

  // Reads are address-driven; the strobe carries no extra information here.
  assign unused_read = reg_read;

  assign reg_wr_hit = reg_write && reg_addrvalid && (reg_address == TPWR_ADDR);
  assign ctrl_wr    = reg_wr_hit && (reg_bytecnt == 16'd0);
  // A CTRL write acts on the same edge it is captured, so decode it ahead of the register.
  assign req_now    = ctrl_wr ? reg_datai[CTRL_PWR_REQ] : power_req_reg;

  assign ramping = (state_reg == ST_SOFTSTART);
  assign running = ramping || (state_reg == ST_SETTLE) || (state_reg == ST_ON);
  assign timed   = (state_reg == ST_SETTLE) || (state_reg == ST_DISCHARGE);

  // SETTLE=0 still spends one cycle in SETTLE.
  assign settle_last = (settle_snap_reg == 8'd0) ? '0 : ({settle_snap_reg, 8'h00} - 16'd1);

`ifdef TPWR_OVERCURRENT_EN
  logic [1:0] oc_sync_reg;

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) oc_sync_reg <= '0;
    else         oc_sync_reg <= {oc_sync_reg[0], oc_fault_i};
  end

  assign fault_now    = oc_sync_reg[1] && running;
  assign fault_clr_ok = ctrl_wr && reg_datai[CTRL_FAULT_CLR] && !reg_datai[CTRL_PWR_REQ];
`else
  assign fault_now    = 1'b0;
  assign fault_clr_ok = 1'b0;
`endif

  tpwr_pwm #(
    .PWM_BITS (PWM_BITS),
    .SS_STEPS (SS_STEPS)
  ) u_pwm (
    .clk       (clk),
    .rst       (reset_i),
    .run       (ramping),
    .ss_div    (ss_div_snap_reg),
    .pwm_on    (pwm_on),
    .ramp_done (ramp_done)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_OFF:       if (req_now) state_next = ST_SOFTSTART;
      ST_SOFTSTART: if (!req_now) state_next = ST_DISCHARGE;
                    else if (ramp_done) state_next = ST_SETTLE;
      ST_SETTLE:    if (!req_now) state_next = ST_DISCHARGE;
                    else if (timer_reg == settle_last) state_next = ST_ON;
      ST_ON:        if (!req_now) state_next = ST_DISCHARGE;
      ST_DISCHARGE: if (timer_reg == DISCH_LAST) state_next = ST_OFF;
      ST_FAULT:     if (fault_clr_ok) state_next = ST_OFF;
      default:      state_next = ST_OFF;
    endcase
    if (fault_now) state_next = ST_FAULT;
  end

  always_comb begin
    rd_byte = 8'h00;
    if (reg_addrvalid && (reg_address == TPWR_ADDR)) begin
      case (reg_bytecnt)
        16'd0:   rd_byte[CTRL_PWR_REQ] = power_req_reg;
        16'd1:   rd_byte = status_byte(state_reg, state_reg == ST_FAULT, state_reg == ST_ON);
        16'd2:   rd_byte = ss_div_reg;
        16'd3:   rd_byte = settle_reg;
        default: rd_byte = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_reg       <= ST_OFF;
      timer_reg       <= '0;
      power_req_reg   <= 1'b0;
      ss_div_reg      <= 8'h00;
      settle_reg      <= 8'h00;
      ss_div_snap_reg <= 8'h00;
      settle_snap_reg <= 8'h00;
      reg_datao       <= 8'h00;
    end else begin
      state_reg <= state_next;
      timer_reg <= (timed && (state_next == state_reg)) ? timer_reg + 16'd1 : '0;
      if (ctrl_wr) power_req_reg <= reg_datai[CTRL_PWR_REQ];
      if (reg_wr_hit && (reg_bytecnt == 16'd2)) ss_div_reg <= reg_datai;
      if (reg_wr_hit && (reg_bytecnt == 16'd3)) settle_reg <= reg_datai;
      // Timing is frozen per sequence so mid-ramp writes cannot disturb it.
      if ((state_reg == ST_OFF) && (state_next == ST_SOFTSTART)) begin
        ss_div_snap_reg <= ss_div_reg;
        settle_snap_reg <= settle_reg;
      end
      reg_datao <= rd_byte;
    end
  end

  assign target_npower = !((ramping && pwm_on) || (state_reg == ST_SETTLE) || (state_reg == ST_ON));
  assign target_highz  = (state_reg != ST_ON);
  assign power_good    = (state_reg == ST_ON);
  assign reg_hyplen    = (reg_hypaddress == TPWR_ADDR) ? 16'd4 : 16'd0;

endmodule

// File: tb/tb_target_power_seq.sv
// Directed bench for target_power_seq: ramp timing, discharge window, snapshots, async reset, register map.
module tb_target_power_seq;
  import target_power_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset_i = 1'b0;
  logic        oc_fault_i = 1'b0;
  logic [5:0]  reg_address = '0;
  logic [15:0] reg_bytecnt = '0;
  logic [7:0]  reg_datai = '0;
  logic [7:0]  reg_datao;
  logic        reg_read = 1'b0;
  logic        reg_write = 1'b0;
  logic        reg_addrvalid = 1'b0;
  logic [5:0]  reg_hypaddress = '0;
  logic [15:0] reg_hyplen;
  logic        target_npower;
  logic        target_highz;
  logic        power_good;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  target_power_seq dut (
    .clk            (clk),
    .reset_i        (reset_i),
`ifdef TPWR_OVERCURRENT_EN
    .oc_fault_i     (oc_fault_i),
`endif
    .reg_address    (reg_address),
    .reg_bytecnt    (reg_bytecnt),
    .reg_datai      (reg_datai),
    .reg_datao      (reg_datao),
    .reg_read       (reg_read),
    .reg_write      (reg_write),
    .reg_addrvalid  (reg_addrvalid),
    .reg_hypaddress (reg_hypaddress),
    .reg_hyplen     (reg_hyplen),
    .target_npower  (target_npower),
    .target_highz   (target_highz),
    .power_good     (power_good)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Bus tasks are entered at a negedge and return at the following negedge.
  task automatic wr(input logic [15:0] bc, input logic [7:0] d);
    reg_address = TPWR_ADDR; reg_bytecnt = bc; reg_datai = d;
    reg_addrvalid = 1'b1; reg_write = 1'b1;
    @(negedge clk);
    reg_write = 1'b0; reg_addrvalid = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, input logic [15:0] bc, output logic [7:0] d);
    reg_address = a; reg_bytecnt = bc; reg_addrvalid = 1'b1; reg_read = 1'b1;
    @(negedge clk);
    d = reg_datao;
    reg_read = 1'b0; reg_addrvalid = 1'b0;
  endtask

  task automatic hold_status_read();
    reg_address = TPWR_ADDR; reg_bytecnt = 16'd1; reg_addrvalid = 1'b1; reg_read = 1'b1;
  endtask

  // Entered at SOFTSTART cycle 0; returns at the first ON sample.
  task automatic run_ramp(output int cyc, output int low0, output int high_tot, output int settle_seen);
    cyc = 0; low0 = 0; high_tot = 0; settle_seen = 0;
    while (target_highz === 1'b1 && cyc < 40000) begin
      if (cyc < 256 && target_npower === 1'b0) low0++;
      if (target_npower === 1'b1) high_tot++;
      if (reg_datao === 8'h02) settle_seen++;
      cyc++;
      @(negedge clk);
    end
    if (reg_datao === 8'h02) settle_seen++;
    reg_read = 1'b0; reg_addrvalid = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    int n, low0, high_tot, settle_seen;

    // Reset state
    #1 reset_i = 1'b1;
    #1;
    check("rst_npower", 32'(target_npower), 32'd1);
    check("rst_highz", 32'(target_highz), 32'd1);
    check("rst_pgood", 32'(power_good), 32'd0);
    check("rst_datao", 32'(reg_datao), 32'd0);
    repeat (2) @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
    rd(TPWR_ADDR, 16'd1, d);
    check("rst_status", 32'(d), 32'h00);

    // 1: ramp SS_DIV=0 (16 periods of 256), SETTLE=1 (256 cycles)
    wr(16'd2, 8'd0);
    wr(16'd3, 8'd1);
    rd(TPWR_ADDR, 16'd3, d);
    check("settle_rb", 32'(d), 32'd1);
    wr(16'd0, 8'd1);
    hold_status_read();
    run_ramp(n, low0, high_tot, settle_seen);
    check("t1_cyc_to_on", 32'(n), 32'd4352);
    check("t1_low_p0", 32'(low0), 32'd16);
    check("t1_high_tot", 32'(high_tot), 32'd1920);
    check("t1_settle_len", 32'(settle_seen), 32'd256);
    check("t1_pgood", 32'(power_good), 32'd1);
    check("t1_npower_on", 32'(target_npower), 32'd0);
    rd(TPWR_ADDR, 16'd1, d);
    check("t1_status_on", 32'(d), 32'h13);

    // 2: power-down from ON, 4096-cycle discharge window
    wr(16'd0, 8'd0);
    check("t2_npower", 32'(target_npower), 32'd1);
    check("t2_highz", 32'(target_highz), 32'd1);
    check("t2_pgood", 32'(power_good), 32'd0);
    hold_status_read();
    n = 0;
    @(negedge clk);
    while (reg_datao === 8'h04 && n < 5000) begin
      n++;
      @(negedge clk);
    end
    check("t2_disch_len", 32'(n), 32'd4096);
    check("t2_status_off", 32'(reg_datao), 32'h00);
    reg_read = 1'b0; reg_addrvalid = 1'b0;

    // 3: drop power_req in ramp period 5, re-request during discharge
    wr(16'd0, 8'd1);
    repeat (5 * 256 + 10) @(negedge clk);
    wr(16'd0, 8'd0);
    check("t3_npower", 32'(target_npower), 32'd1);
    check("t3_highz", 32'(target_highz), 32'd1);
    wr(16'd0, 8'd1);
    n = 0;
    while (target_npower === 1'b1 && n < 10000) begin
      n++;
      @(negedge clk);
    end
    check("t3_wait_off", 32'(n), 32'd4096);
    low0 = 0;
    for (int i = 0; i < 256; i++) begin
      if (target_npower === 1'b0) low0++;
      @(negedge clk);
    end
    check("t3_restart_p0", 32'(low0), 32'd16);

    // 4: mid-ramp writes only affect the next sequence
    wr(16'd2, 8'd3);
    wr(16'd3, 8'd0);
    n = 0;
    while (target_highz === 1'b1 && n < 10000) begin
      n++;
      @(negedge clk);
    end
    check("t4_cur_ramp", 32'(n), 32'd4094);
    wr(16'd0, 8'd0);
    repeat (4100) @(negedge clk);
    wr(16'd0, 8'd1);
    hold_status_read();
    run_ramp(n, low0, high_tot, settle_seen);
    check("t4_cyc_to_on", 32'(n), 32'd16385);
    check("t4_low_p0", 32'(low0), 32'd16);
    check("t4_high_tot", 32'(high_tot), 32'd7680);
    check("t4_settle_len", 32'(settle_seen), 32'd1);

    // 5: asynchronous reset mid-SETTLE, then register map edges
    wr(16'd3, 8'd4);
    wr(16'd0, 8'd0);
    repeat (4100) @(negedge clk);
    wr(16'd2, 8'd0);
    wr(16'd0, 8'd1);
    hold_status_read();
    repeat (4396) @(negedge clk);
    check("t5_in_settle", 32'(reg_datao), 32'h02);
    check("t5_npower_pre", 32'(target_npower), 32'd0);
    #2 reset_i = 1'b1;
    #1;
    check("t5_async_npwr", 32'(target_npower), 32'd1);
    check("t5_async_highz", 32'(target_highz), 32'd1);
    check("t5_async_datao", 32'(reg_datao), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_i = 1'b0;
    reg_read = 1'b0; reg_addrvalid = 1'b0;
    @(negedge clk);
    rd(TPWR_ADDR, 16'd0, d);
    check("t5_ctrl_rst", 32'(d), 32'd0);
    rd(TPWR_ADDR, 16'd3, d);
    check("t5_settle_rst", 32'(d), 32'd0);
    wr(16'd2, 8'd7);
    rd(TPWR_ADDR, 16'd2, d);
    check("t5_ssdiv_rb", 32'(d), 32'd7);
    rd(TPWR_ADDR, 16'd4, d);
    check("t5_byte4", 32'(d), 32'd0);
    rd(TPWR_ADDR ^ 6'd1, 16'd2, d);
    check("t5_unmatched", 32'(d), 32'd0);
    reg_hypaddress = TPWR_ADDR;
    #1 check("t5_hyplen_hit", 32'(reg_hyplen), 32'd4);
    reg_hypaddress = TPWR_ADDR ^ 6'd1;
    #1 check("t5_hyplen_miss", 32'(reg_hyplen), 32'd0);
    @(negedge clk);

`ifdef TPWR_OVERCURRENT_EN
    // 6: overcurrent trip from ON and fault clearing rules
    wr(16'd2, 8'd0);
    wr(16'd3, 8'd0);
    wr(16'd0, 8'd1);
    repeat (4200) @(negedge clk);
    check("t6_pgood_on", 32'(power_good), 32'd1);
    oc_fault_i = 1'b1;
    @(negedge clk);
    oc_fault_i = 1'b0;
    n = 1;
    while (power_good === 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("t6_trip_le3", 32'(n <= 3), 32'd1);
    rd(TPWR_ADDR, 16'd1, d);
    check("t6_status_flt", 32'(d), 32'h0D);
    check("t6_npower", 32'(target_npower), 32'd1);
    wr(16'd0, 8'h81);
    rd(TPWR_ADDR, 16'd1, d);
    check("t6_clr_ignored", 32'(d), 32'h0D);
    wr(16'd0, 8'h00);
    rd(TPWR_ADDR, 16'd1, d);
    check("t6_req0_hold", 32'(d), 32'h0D);
    wr(16'd0, 8'h80);
    rd(TPWR_ADDR, 16'd1, d);
    check("t6_cleared", 32'(d), 32'h00);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
